// File: rtl/ahbl_sram_excl.sv
// ahbl_sram_excl: zero-wait-state AHB-Lite SRAM slave with a per-master
// exclusive reservation monitor (LR/SC and AMO responder).
// Optional feature macro: AHBL_SRAM_EXCL_RANGE_ERR_EN
//   defined   -> out-of-range and misaligned transfers get a two-cycle ERROR
//   undefined -> upper address bits alias, misaligned accesses use the
//                aligned-down lanes, hresp tied 0 and hready_resp tied 1
module ahbl_sram_excl #(
    parameter int W_ADDR     = 32,
    parameter int DEPTH      = 1024,
    parameter int N_MONITORS = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ahbls_hready,
    output logic              o_ahbls_hready_resp,
    output logic              o_ahbls_hresp,
    input  logic [W_ADDR-1:0] i_ahbls_haddr,
    input  logic              i_ahbls_hwrite,
    input  logic [1:0]        i_ahbls_htrans,
    input  logic [2:0]        i_ahbls_hsize,
    input  logic [2:0]        i_ahbls_hburst,
    input  logic [3:0]        i_ahbls_hprot,
    input  logic              i_ahbls_hmastlock,
    input  logic [31:0]       i_ahbls_hwdata,
    output logic [31:0]       o_ahbls_hrdata,
    input  logic              i_ahbls_hexcl,
    input  logic [7:0]        i_ahbls_hmaster,
    output logic              o_ahbls_hexokay
);

    localparam int AW = $clog2(DEPTH);
    localparam int MW = (N_MONITORS > 1) ? $clog2(N_MONITORS) : 1;

    // Address-phase decode
    logic          w_trans;
    logic [AW-1:0] w_aWord;
    logic [3:0]    w_aLanes;
    logic          w_addrErr;
    logic          w_hreadyResp;
    logic          w_hresp;

    // Data-phase state
    logic          r_dpValid;
    logic [AW-1:0] r_dpWord;
    logic [3:0]    r_dpLanes;
    logic          r_dpWrite;
    logic          r_dpExcl;
    logic [7:0]    r_dpMaster;

    // Memory, read data and reservation monitor
    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_rdata;
    logic [N_MONITORS-1:0] r_monValid;
    logic [AW-1:0]         r_monWord [N_MONITORS];

    logic [31:0]   w_dpMaster32;
    logic [MW-1:0] w_monIdx;
    logic          w_idInRange;
    logic          w_monHit;
    logic          w_exclOk;
    logic          w_doWrite;
    logic [31:0]   w_mergeData;
    logic          w_unused;

    assign w_unused = ^{i_ahbls_hburst, i_ahbls_hprot, i_ahbls_hmastlock, i_ahbls_haddr};

    assign w_trans = i_ahbls_hready & i_ahbls_htrans[1];
    assign w_aWord = i_ahbls_haddr[2 +: AW];

    // Byte lanes from transfer size and low address bits; oversize is a word
    always_comb begin
        w_aLanes = 4'b1111;
        case (i_ahbls_hsize)
            3'd0:    w_aLanes = 4'b0001 << i_ahbls_haddr[1:0];
            3'd1:    w_aLanes = i_ahbls_haddr[1] ? 4'b1100 : 4'b0011;
            default: w_aLanes = 4'b1111;
        endcase
    end

`ifdef AHBL_SRAM_EXCL_RANGE_ERR_EN
    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_stateNext;
    logic   w_misaligned;

    assign w_misaligned = ((i_ahbls_hsize == 3'd1) && i_ahbls_haddr[0]) ||
                          ((i_ahbls_hsize >= 3'd2) && (i_ahbls_haddr[1:0] != 2'b00));
    assign w_addrErr    = ((i_ahbls_haddr >> (2 + AW)) != '0) || w_misaligned;

    // Error response state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_OKAY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Two-cycle ERROR sequence: stall with hresp, then release with hresp
    always_comb begin
        w_stateNext  = r_state;
        w_hreadyResp = 1'b1;
        w_hresp      = 1'b0;
        case (r_state)
            ST_OKAY: begin
                if (w_trans && w_addrErr) w_stateNext = ST_ERR1;
            end
            ST_ERR1: begin
                w_hreadyResp = 1'b0;
                w_hresp      = 1'b1;
                w_stateNext  = ST_ERR2;
            end
            ST_ERR2: begin
                w_hresp     = 1'b1;
                w_stateNext = (w_trans && w_addrErr) ? ST_ERR1 : ST_OKAY;
            end
            default: w_stateNext = ST_OKAY;
        endcase
    end
`else
    assign w_addrErr    = 1'b0;
    assign w_hreadyResp = 1'b1;
    assign w_hresp      = 1'b0;
`endif

    // Capture the address phase into data-phase state; errored transfers stay invalid
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dpValid  <= 1'b0;
            r_dpWord   <= '0;
            r_dpLanes  <= '0;
            r_dpWrite  <= 1'b0;
            r_dpExcl   <= 1'b0;
            r_dpMaster <= '0;
        end else begin
            r_dpValid <= w_trans & ~w_addrErr;
            if (w_trans) begin
                r_dpWord   <= w_aWord;
                r_dpLanes  <= w_aLanes;
                r_dpWrite  <= i_ahbls_hwrite;
                r_dpExcl   <= i_ahbls_hexcl;
                r_dpMaster <= i_ahbls_hmaster;
            end
        end
    end

    // Monitor lookup for the transfer currently in its data phase
    assign w_dpMaster32 = {24'd0, r_dpMaster};
    assign w_idInRange  = w_dpMaster32 < N_MONITORS;
    assign w_monIdx     = r_dpMaster[MW-1:0];
    assign w_monHit     = w_idInRange && r_monValid[w_monIdx] &&
                          (r_monWord[w_monIdx] == r_dpWord);
    assign w_exclOk     = r_dpExcl & w_idInRange & (r_dpWrite ? w_monHit : 1'b1);
    assign w_doWrite    = r_dpValid & r_dpWrite & (~r_dpExcl | w_exclOk);

    // Write data merged onto the current word, used for both the store and the bypass
    always_comb begin
        w_mergeData = r_mem[r_dpWord];
        for (int b = 0; b < 4; b++) begin
            if (r_dpLanes[b]) w_mergeData[8*b +: 8] = i_ahbls_hwdata[8*b +: 8];
        end
    end

    // Byte-lane store at the edge ending a committed write data phase
    always_ff @(posedge i_clk) begin
        if (w_doWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (r_dpLanes[b]) r_mem[r_dpWord][8*b +: 8] <= i_ahbls_hwdata[8*b +: 8];
            end
        end
    end

    // Read at the address-phase edge, bypassing a same-word write finishing now
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (w_trans && !w_addrErr && !i_ahbls_hwrite) begin
            if (w_doWrite && (r_dpWord == w_aWord)) begin
                r_rdata <= w_mergeData;
            end else begin
                r_rdata <= r_mem[w_aWord];
            end
        end
    end

    // Reservations: exclusive reads set, committed writes clear matching words
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_monValid <= '0;
            for (int i = 0; i < N_MONITORS; i++) r_monWord[i] <= '0;
        end else begin
            if (w_doWrite) begin
                for (int i = 0; i < N_MONITORS; i++) begin
                    if (r_monWord[i] == r_dpWord) r_monValid[i] <= 1'b0;
                end
            end
            if (r_dpValid && r_dpExcl && !r_dpWrite && w_idInRange) begin
                r_monValid[w_monIdx] <= 1'b1;
                r_monWord[w_monIdx]  <= r_dpWord;
            end
        end
    end

    assign o_ahbls_hready_resp = w_hreadyResp;
    assign o_ahbls_hresp       = w_hresp;
    assign o_ahbls_hrdata      = r_rdata;
    assign o_ahbls_hexokay     = r_dpValid & w_exclOk & w_hreadyResp;

endmodule

// File: tb/tb_ahbl_sram_excl.sv
// Directed testbench for ahbl_sram_excl: data path, bypass, byte lanes,
// exclusive monitor behaviour, reset and (with the macro) ERROR responses.
module tb_ahbl_sram_excl;

    logic        clk = 1'b0;
    logic        rstN;
    logic        busHready;
    logic        hreadyResp;
    logic        hresp;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hexcl;
    logic [7:0]  hmaster;
    logic        hexokay;

    int errors = 0;
    int checks = 0;

    logic        obsReady;
    logic        obsResp;
    logic [31:0] obsRdata;
    logic        obsOkay;

    // Single-slave system: the bus hready is this slave's own ready
    assign busHready = hreadyResp;

    // 10 ns clock
    always #5 clk = ~clk;

    ahbl_sram_excl dut (
        .i_clk               (clk),
        .i_rst_n             (rstN),
        .i_ahbls_hready      (busHready),
        .o_ahbls_hready_resp (hreadyResp),
        .o_ahbls_hresp       (hresp),
        .i_ahbls_haddr       (haddr),
        .i_ahbls_hwrite      (hwrite),
        .i_ahbls_htrans      (htrans),
        .i_ahbls_hsize       (hsize),
        .i_ahbls_hburst      (3'b000),
        .i_ahbls_hprot       (4'b0011),
        .i_ahbls_hmastlock   (1'b0),
        .i_ahbls_hwdata      (hwdata),
        .o_ahbls_hrdata      (hrdata),
        .i_ahbls_hexcl       (hexcl),
        .i_ahbls_hmaster     (hmaster),
        .o_ahbls_hexokay     (hexokay)
    );

    // One comparison: count it, and report tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One isolated transfer; data-phase outputs are captured into obs*.
    // Called and returns at 1 ns after a rising edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic write,
                                 input logic [2:0] size, input logic excl,
                                 input logic [7:0] master, input logic [31:0] wdata);
        haddr   = addr;
        hwrite  = write;
        hsize   = size;
        hexcl   = excl;
        hmaster = master;
        htrans  = 2'b10;
        @(posedge clk); #1;
        htrans   = 2'b00;
        hwrite   = 1'b0;
        hexcl    = 1'b0;
        hwdata   = wdata;
        obsReady = hreadyResp;
        obsResp  = hresp;
        obsRdata = hrdata;
        obsOkay  = hexokay;
        @(posedge clk); #1;
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        rstN = 1'b0; haddr = '0; hwrite = 1'b0; htrans = 2'b00; hsize = 3'd2;
        hwdata = '0; hexcl = 1'b0; hmaster = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_hready_resp", 32'(hreadyResp), 32'd1);
        checkOutput("rst_hresp", 32'(hresp), 32'd0);
        checkOutput("rst_hrdata", hrdata, 32'd0);
        checkOutput("rst_hexokay", 32'(hexokay), 32'd0);
        rstN = 1'b1;
        @(posedge clk); #1;

        // Back-to-back word write then read of 0x10 through the bypass
        haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        @(posedge clk); #1;
        haddr = 32'h10; hwrite = 1'b0; htrans = 2'b10; hwdata = 32'hDEADBEEF;
        checkOutput("b2b_wr_ready", 32'(hreadyResp), 32'd1);
        @(posedge clk); #1;
        htrans = 2'b00;
        checkOutput("b2b_rd_ready", 32'(hreadyResp), 32'd1);
        checkOutput("b2b_rd_bypass", hrdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Byte and halfword lanes
        applyStimulus(32'h10, 1'b1, 3'd2, 1'b0, 8'd0, 32'h11223344);
        applyStimulus(32'h13, 1'b1, 3'd0, 1'b0, 8'd0, 32'hAAAAAAAA);
        applyStimulus(32'h10, 1'b0, 3'd2, 1'b0, 8'd0, 32'h0);
        checkOutput("byte_write_lane3", obsRdata, 32'hAA223344);
        applyStimulus(32'h12, 1'b1, 3'd1, 1'b0, 8'd0, 32'hBEEF0000);
        applyStimulus(32'h10, 1'b0, 3'd2, 1'b0, 8'd0, 32'h0);
        checkOutput("half_write_upper", obsRdata, 32'hBEEF3344);

`ifndef AHBL_SRAM_EXCL_RANGE_ERR_EN
        // Aliasing modulo DEPTH words and aligned-down misaligned word
        applyStimulus(32'h1010, 1'b0, 3'd2, 1'b0, 8'd0, 32'h0);
        checkOutput("alias_read", obsRdata, 32'hBEEF3344);
        applyStimulus(32'h21, 1'b1, 3'd2, 1'b0, 8'd0, 32'h12345678);
        applyStimulus(32'h20, 1'b0, 3'd2, 1'b0, 8'd0, 32'h0);
        checkOutput("misaligned_word", obsRdata, 32'h12345678);
`endif

        // Master 0 exclusive pair, then a repeated SC fails
        applyStimulus(32'h40, 1'b0, 3'd2, 1'b1, 8'd0, 32'h0);
        checkOutput("m0_lr_okay", 32'(obsOkay), 32'd1);
        applyStimulus(32'h40, 1'b1, 3'd2, 1'b1, 8'd0, 32'h5);
        checkOutput("m0_sc_okay", 32'(obsOkay), 32'd1);
        applyStimulus(32'h40, 1'b0, 3'd2, 1'b0, 8'd0, 32'h0);
        checkOutput("m0_sc_data", obsRdata, 32'h5);
        checkOutput("plain_rd_okay", 32'(obsOkay), 32'd0);
        applyStimulus(32'h40, 1'b1, 3'd2, 1'b1, 8'd0, 32'h6);
        checkOutput("m0_sc2_fail", 32'(obsOkay), 32'd0);
        checkOutput("m0_sc2_resp", 32'(obsResp), 32'd0);
        applyStimulus(32'h40, 1'b0, 3'd2, 1'b0, 8'd0, 32'h0);
        checkOutput("m0_sc2_kept", obsRdata, 32'h5);

        // Two masters reserve 0x80; master 1 wins
        applyStimulus(32'h80, 1'b0, 3'd2, 1'b1, 8'd0, 32'h0);
        applyStimulus(32'h80, 1'b0, 3'd2, 1'b1, 8'd1, 32'h0);
        checkOutput("m1_lr_okay", 32'(obsOkay), 32'd1);
        applyStimulus(32'h80, 1'b1, 3'd2, 1'b1, 8'd1, 32'h7);
        checkOutput("m1_sc_okay", 32'(obsOkay), 32'd1);
        applyStimulus(32'h80, 1'b1, 3'd2, 1'b1, 8'd0, 32'h8);
        checkOutput("m0_sc_lost", 32'(obsOkay), 32'd0);
        applyStimulus(32'h80, 1'b0, 3'd2, 1'b0, 8'd0, 32'h0);
        checkOutput("race_data", obsRdata, 32'h7);

        // Plain write by another master breaks the reservation
        applyStimulus(32'h100, 1'b0, 3'd2, 1'b1, 8'd0, 32'h0);
        applyStimulus(32'h100, 1'b1, 3'd2, 1'b0, 8'd1, 32'h9);
        checkOutput("plain_wr_okay", 32'(obsOkay), 32'd0);
        applyStimulus(32'h100, 1'b1, 3'd2, 1'b1, 8'd0, 32'hA);
        checkOutput("m0_sc_broken", 32'(obsOkay), 32'd0);
        applyStimulus(32'h100, 1'b0, 3'd2, 1'b0, 8'd0, 32'h0);
        checkOutput("broken_data", obsRdata, 32'h9);

        // Out-of-range master ID: data returned, never exclusive-okay
        applyStimulus(32'h100, 1'b0, 3'd2, 1'b1, 8'd5, 32'h0);
        checkOutput("m5_lr_okay", 32'(obsOkay), 32'd0);
        checkOutput("m5_lr_data", obsRdata, 32'h9);
        applyStimulus(32'h100, 1'b1, 3'd2, 1'b1, 8'd5, 32'hB);
        checkOutput("m5_sc_okay", 32'(obsOkay), 32'd0);
        applyStimulus(32'h100, 1'b0, 3'd2, 1'b0, 8'd0, 32'h0);
        checkOutput("m5_sc_suppressed", obsRdata, 32'h9);

        // A write to a neighbouring word leaves the reservation intact
        applyStimulus(32'h200, 1'b0, 3'd2, 1'b1, 8'd0, 32'h0);
        applyStimulus(32'h204, 1'b1, 3'd2, 1'b0, 8'd1, 32'h3);
        applyStimulus(32'h200, 1'b1, 3'd2, 1'b1, 8'd0, 32'h22);
        checkOutput("other_word_sc_okay", 32'(obsOkay), 32'd1);
        applyStimulus(32'h200, 1'b0, 3'd2, 1'b0, 8'd0, 32'h0);
        checkOutput("other_word_data", obsRdata, 32'h22);

        // Reset during a write data phase drops the write and reservations
        applyStimulus(32'h300, 1'b1, 3'd2, 1'b0, 8'd0, 32'h1234);
        applyStimulus(32'h300, 1'b0, 3'd2, 1'b1, 8'd0, 32'h0);
        haddr = 32'h300; hwrite = 1'b1; hsize = 3'd2; hexcl = 1'b0; htrans = 2'b10;
        @(posedge clk); #1;
        htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h55;
        rstN = 1'b0;
        #1;
        checkOutput("midrst_hrdata", hrdata, 32'd0);
        checkOutput("midrst_hexokay", 32'(hexokay), 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        applyStimulus(32'h300, 1'b1, 3'd2, 1'b1, 8'd0, 32'h77);
        checkOutput("midrst_sc_fail", 32'(obsOkay), 32'd0);
        applyStimulus(32'h300, 1'b0, 3'd2, 1'b0, 8'd0, 32'h0);
        checkOutput("midrst_wr_dropped", obsRdata, 32'h1234);

`ifdef AHBL_SRAM_EXCL_RANGE_ERR_EN
        // Out-of-range read: two-cycle ERROR then back to OKAY
        haddr = 32'h10000; hwrite = 1'b0; hsize = 3'd2; htrans = 2'b10;
        @(posedge clk); #1;
        htrans = 2'b00;
        checkOutput("err1_ready", 32'(hreadyResp), 32'd0);
        checkOutput("err1_resp", 32'(hresp), 32'd1);
        @(posedge clk); #1;
        checkOutput("err2_ready", 32'(hreadyResp), 32'd1);
        checkOutput("err2_resp", 32'(hresp), 32'd1);
        @(posedge clk); #1;
        checkOutput("err_done_resp", 32'(hresp), 32'd0);

        // Misaligned word write errors and leaves memory untouched
        applyStimulus(32'h41, 1'b1, 3'd2, 1'b0, 8'd0, 32'hFFFF);
        checkOutput("misalign_ready", 32'(obsReady), 32'd0);
        checkOutput("misalign_resp", 32'(obsResp), 32'd1);
        @(posedge clk); #1;
        applyStimulus(32'h40, 1'b0, 3'd2, 1'b0, 8'd0, 32'h0);
        checkOutput("misalign_no_write", obsRdata, 32'h5);

        // Reset during ERROR returns outputs to reset values at once
        haddr = 32'h10000; hwrite = 1'b0; htrans = 2'b10;
        @(posedge clk); #1;
        htrans = 2'b00;
        rstN = 1'b0;
        #1;
        checkOutput("rst_in_err_ready", 32'(hreadyResp), 32'd1);
        checkOutput("rst_in_err_resp", 32'(hresp), 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
